// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access engine.
// Turns the EX/MEM memory-op outputs into an SRAM-like req/addr_ok/data_ok
// transaction. It stalls the pipeline while the transaction is in flight,
// formats store data, aligns and extends load data, and flags misaligned
// addresses (AdEL/AdES).
// Optional feature macro: MEM_STALL_CNT_EN. When it is defined, stall_cnt
// counts the cycles in which mem_stall is high. When it is not defined,
// stall_cnt is tied to zero.
module mem_access_unit #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          op_valid,
  input  logic          op_wr,
  input  logic [3:0]    mem_ctrl,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          flush,
  output logic          data_sram_req,
  output logic          data_sram_wr,
  output logic [1:0]    data_sram_size,
  output logic [AW-1:0] data_sram_addr,
  output logic [DW-1:0] data_sram_wdata,
  input  logic          data_sram_addr_ok,
  input  logic          data_sram_data_ok,
  input  logic [DW-1:0] data_sram_rdata,
  output logic          mem_stall,
  output logic          adel,
  output logic          ades,
  output logic [DW-1:0] load_data,
  output logic          load_valid,
  output logic [31:0]   stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [2:0] T_WORD = 3'b000;
  localparam logic [2:0] T_HS   = 3'b001;
  localparam logic [2:0] T_HU   = 3'b010;
  localparam logic [2:0] T_BS   = 3'b011;
  localparam logic [2:0] T_BU   = 3'b100;

  // Access size implied by the type field. Codes that are not listed fall
  // back to a word access.
  function automatic logic [1:0] size_of(input logic [2:0] t);
    logic [1:0] s;
    s = SZ_WORD;
    if (t == T_HS || t == T_HU) s = SZ_HALF;
    else if (t == T_BS || t == T_BU) s = SZ_BYTE;
    return s;
  endfunction

  // Replicate the store operand across every lane the SRAM may write.
  function automatic logic [DW-1:0] format_wdata(input logic [1:0] sz,
                                                 input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
    if (sz == SZ_BYTE) r = {4{d[7:0]}};
    else if (sz == SZ_HALF) r = {2{d[15:0]}};
    return r;
  endfunction

  // Select the addressed lane of the read word, then sign- or zero-extend it.
  function automatic logic [DW-1:0] extract_load(input logic [2:0] t,
                                                 input logic [1:0] lane,
                                                 input logic [DW-1:0] d);
    logic [7:0]    b;
    logic [15:0]   h;
    logic [DW-1:0] r;
    case (lane)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lane[1] ? d[31:16] : d[15:0];
    case (t)
      T_HS:    r = {{16{h[15]}}, h};
      T_HU:    r = {16'h0000, h};
      T_BS:    r = {{24{b[7]}}, b};
      T_BU:    r = {24'h000000, b};
      default: r = d;
    endcase
    return r;
  endfunction

  state_t        state_q, state_d;
  logic          wr_q, wr_d;
  logic [1:0]    size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [1:0]    lane_q, lane_d;
  logic          cancel_q, cancel_d;
  logic [DW-1:0] load_data_q, load_data_d;
  logic          load_valid_q, load_valid_d;

  logic [1:0]    op_size;
  logic          misaligned;
  logic          start;
  logic          unused_ctrl_bit;

  // mem_ctrl[3] is reserved, so it does not affect decoding.
  assign unused_ctrl_bit = mem_ctrl[3];

  // Decode the incoming op. Alignment errors are combinational, so the
  // exception logic can see them in the same cycle.
  always_comb begin
    op_size    = size_of(mem_ctrl[2:0]);
    misaligned = 1'b0;
    if (op_size == SZ_WORD && addr[1:0] != 2'b00) misaligned = 1'b1;
    if (op_size == SZ_HALF && addr[0]) misaligned = 1'b1;
    adel  = op_valid & ~op_wr & misaligned;
    ades  = op_valid & op_wr & misaligned;
    start = op_valid & ~misaligned & ~flush;
  end

  // Next-state logic plus the request latch and the load-result update.
  always_comb begin
    state_d      = state_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ctrl_d       = ctrl_q;
    lane_d       = lane_q;
    cancel_d     = cancel_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        if (start) begin
          wr_d    = op_wr;
          size_d  = op_size;
          addr_d  = addr;
          wdata_d = format_wdata(op_size, wdata);
          ctrl_d  = mem_ctrl[2:0];
          lane_d  = addr[1:0];
          state_d = REQ;
        end
      end
      REQ: begin
        if (flush) cancel_d = 1'b1;
        if (data_sram_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (flush) cancel_d = 1'b1;
        // data_ok is honoured only here. A data_ok that arrives together
        // with addr_ok (in REQ) is ignored.
        if (data_sram_data_ok) begin
          state_d  = IDLE;
          cancel_d = 1'b0;
          // A flush in the final cycle also suppresses the result.
          if (!wr_q && !cancel_q && !flush) begin
            load_data_d  = extract_load(ctrl_q, lane_q, data_sram_rdata);
            load_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset returns everything to idle
  // immediately. Any response still outstanding is not tracked.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      addr_q       <= '0;
      wdata_q      <= '0;
      ctrl_q       <= 3'b000;
      lane_q       <= 2'b00;
      cancel_q     <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ctrl_q       <= ctrl_d;
      lane_q       <= lane_d;
      cancel_q     <= cancel_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
    end
  end

  // Request fields come only from latched values, so they stay stable
  // until the SRAM accepts the address.
  always_comb begin
    data_sram_req   = (state_q == REQ);
    data_sram_wr    = wr_q;
    data_sram_size  = size_q;
    data_sram_addr  = addr_q;
    data_sram_wdata = wdata_q;
    load_data       = load_data_q;
    load_valid      = load_valid_q;
  end

  // Stall drops in the data_ok cycle, so EX/MEM advances on that edge.
  always_comb begin
    mem_stall = ((state_q == IDLE) & start) |
                (state_q == REQ) |
                ((state_q == WAIT) & ~data_sram_data_ok);
  end

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Free-running count of stalled cycles. It wraps naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, mem_stall};
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard testbench for mem_access_unit. Stimulus pushes the expected SRAM
// requests and load results into queues. A monitor pops and compares them
// whenever the DUT hands over a request or pulses load_valid.
module tb_mem_access_unit;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clock;
  logic        reset;
  logic        op_valid;
  logic        op_wr;
  logic [3:0]  mem_ctrl;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_stall;
  logic        adel;
  logic        ades;
  logic [31:0] load_data;
  logic        load_valid;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  req_t        req_exp[$];
  logic [31:0] load_exp[$];

  mem_access_unit #(.AW(32), .DW(32)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_wr(op_wr),
    .mem_ctrl(mem_ctrl), .addr(addr), .wdata(wdata), .flush(flush),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .mem_stall(mem_stall), .adel(adel), .ades(ades), .load_data(load_data),
    .load_valid(load_valid), .stall_cnt(stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: compare every accepted request and every load result pulse.
  initial begin
    req_t r;
    forever begin
      @(negedge clock);
      if (reset) begin
        if (data_sram_req && data_sram_addr_ok) begin
          if (req_exp.size() == 0) begin
            check("unexpected_req", 32'd1, 32'd0);
          end else begin
            r = req_exp.pop_front();
            check("req_wr", {31'd0, data_sram_wr}, {31'd0, r.wr});
            check("req_size", {30'd0, data_sram_size}, {30'd0, r.size});
            check("req_addr", data_sram_addr, r.addr);
            check("req_wdata", data_sram_wdata, r.wdata);
          end
        end
        if (load_valid) begin
          if (load_exp.size() == 0) check("unexpected_load_valid", 32'd1, 32'd0);
          else check("load_data", load_data, load_exp.pop_front());
        end
      end
    end
  end

  // One complete transaction. aok = number of REQ cycles before addr_ok;
  // dok = number of cycles after addr_ok until data_ok (at least 1).
  task automatic run_op(input logic wr, input logic [3:0] ctrl,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int aok, input int dok,
                        input logic fl_wait, input logic [1:0] xsize,
                        input logic [31:0] xwdata, input logic [31:0] xload);
    req_t r;
    r.wr = wr; r.size = xsize; r.addr = a; r.wdata = xwdata;
    req_exp.push_back(r);
    if (!wr && !fl_wait) load_exp.push_back(xload);
    op_valid = 1'b1; op_wr = wr; mem_ctrl = ctrl; addr = a; wdata = wd;
    @(negedge clock);
    check("stall_issue", {31'd0, mem_stall}, 32'd1);
    @(posedge clock); #1;
    for (int i = 0; i < aok; i++) begin
      @(negedge clock);
      check("req_held", {31'd0, data_sram_req}, 32'd1);
      @(posedge clock); #1;
    end
    data_sram_addr_ok = 1'b1;
    @(negedge clock);
    check("req_stall", {31'd0, mem_stall}, 32'd1);
    @(posedge clock); #1;
    data_sram_addr_ok = 1'b0;
    for (int i = 0; i < dok - 1; i++) begin
      if (i == 0 && fl_wait) flush = 1'b1;
      @(negedge clock);
      check("wait_stall", {31'd0, mem_stall}, 32'd1);
      check("wait_noreq", {31'd0, data_sram_req}, 32'd0);
      @(posedge clock); #1;
      flush = 1'b0;
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = rd;
    @(negedge clock);
    check("dataok_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clock); #1;
    data_sram_data_ok = 1'b0; op_valid = 1'b0; data_sram_rdata = 32'h0;
    @(negedge clock);
    check("after_op_noreq", {31'd0, data_sram_req}, 32'd0);
    @(posedge clock); #1;
  endtask

  // Misaligned op: it must raise the error flag without a request or a stall.
  task automatic err_op(input logic wr, input logic [3:0] ctrl,
                        input logic [31:0] a, input logic xadel,
                        input logic xades);
    op_valid = 1'b1; op_wr = wr; mem_ctrl = ctrl; addr = a; wdata = 32'h0;
    @(negedge clock);
    check("err_adel", {31'd0, adel}, {31'd0, xadel});
    check("err_ades", {31'd0, ades}, {31'd0, xades});
    check("err_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clock); #1;
    op_valid = 1'b0;
    @(negedge clock);
    check("err_noreq", {31'd0, data_sram_req}, 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b0; op_valid = 1'b0; op_wr = 1'b0; mem_ctrl = 4'h0;
    addr = 32'h0; wdata = 32'h0; flush = 1'b0;
    data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_req", {31'd0, data_sram_req}, 32'd0);
    check("rst_load_data", load_data, 32'h0);
    check("rst_load_valid", {31'd0, load_valid}, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // LW: addr_ok one cycle late, data_ok two cycles after addr_ok.
    run_op(1'b0, 4'h0, 32'h1000, 32'h12345678, 32'h8899AABB, 1, 2, 1'b0,
           2'd2, 32'h12345678, 32'h8899AABB);
    // Sub-word loads from read word 0x80112233.
    run_op(1'b0, 4'h3, 32'h1003, 32'h0, 32'h80112233, 0, 1, 1'b0,
           2'd0, 32'h0, 32'hFFFFFF80);
    run_op(1'b0, 4'h4, 32'h1003, 32'h0, 32'h80112233, 0, 1, 1'b0,
           2'd0, 32'h0, 32'h00000080);
    run_op(1'b0, 4'h1, 32'h1002, 32'h0, 32'h80112233, 0, 1, 1'b0,
           2'd1, 32'h0, 32'hFFFF8011);
    run_op(1'b0, 4'h2, 32'h1000, 32'h0, 32'h80112233, 1, 1, 1'b0,
           2'd1, 32'h0, 32'h00002233);
    run_op(1'b0, 4'hB, 32'h1001, 32'h0, 32'h80112233, 0, 2, 1'b0,
           2'd0, 32'h0, 32'h00000022);
    // Stores: lanes replicated, and no load_valid pulse.
    run_op(1'b1, 4'h3, 32'h2001, 32'h000000A5, 32'h0, 0, 1, 1'b0,
           2'd0, 32'hA5A5A5A5, 32'h0);
    run_op(1'b1, 4'h1, 32'h2002, 32'h1234BEEF, 32'h0, 2, 1, 1'b0,
           2'd1, 32'hBEEFBEEF, 32'h0);
    run_op(1'b1, 4'h0, 32'h2004, 32'hDEADBEEF, 32'h0, 0, 3, 1'b0,
           2'd2, 32'hDEADBEEF, 32'h0);
    // Address errors.
    err_op(1'b0, 4'h0, 32'h1002, 1'b1, 1'b0);
    err_op(1'b1, 4'h1, 32'h3001, 1'b0, 1'b1);
    err_op(1'b1, 4'h0, 32'h3003, 1'b0, 1'b1);
    err_op(1'b0, 4'h2, 32'h1001, 1'b1, 1'b0);
    // Flush in WAIT: the transaction drains and the result is suppressed.
    run_op(1'b0, 4'h0, 32'h1100, 32'h0, 32'hCAFEF00D, 0, 3, 1'b1,
           2'd2, 32'h0, 32'h0);
    // The next op is accepted normally.
    run_op(1'b0, 4'h0, 32'h1104, 32'h0, 32'h0BADF00D, 0, 1, 1'b0,
           2'd2, 32'h0, 32'h0BADF00D);
    // Flush in IDLE: no stall and no request.
    op_valid = 1'b1; op_wr = 1'b0; mem_ctrl = 4'h0; addr = 32'h1200; flush = 1'b1;
    @(negedge clock);
    check("flush_idle_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clock); #1;
    op_valid = 1'b0; flush = 1'b0;
    @(negedge clock);
    check("flush_idle_noreq", {31'd0, data_sram_req}, 32'd0);
    @(posedge clock); #1;

    // Reset asserted while in REQ.
    begin
      req_t r;
      r.wr = 1'b0; r.size = 2'd2; r.addr = 32'h1300; r.wdata = 32'h0;
      req_exp.push_back(r);
    end
    op_valid = 1'b1; op_wr = 1'b0; mem_ctrl = 4'h0; addr = 32'h1300; wdata = 32'h0;
    @(posedge clock); #1;
    @(negedge clock);
    check("pre_rst_req", {31'd0, data_sram_req}, 32'd1);
    #1;
    op_valid = 1'b0; reset = 1'b0;
    #1;
    check("midrst_req", {31'd0, data_sram_req}, 32'd0);
    check("midrst_stall", {31'd0, mem_stall}, 32'd0);
    check("midrst_stall_cnt", stall_cnt, 32'd0);
    void'(req_exp.pop_front());
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // Minimum-length op after reset: it stalls in exactly two cycles.
    run_op(1'b0, 4'h0, 32'h1400, 32'h0, 32'h55AA55AA, 0, 1, 1'b0,
           2'd2, 32'h0, 32'h55AA55AA);
`ifdef MEM_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 32'd2);
`else
    check("stall_cnt_tied", stall_cnt, 32'd0);
`endif

    repeat (2) @(posedge clock);
    check("req_queue_empty", req_exp.size(), 32'd0);
    check("load_queue_empty", load_exp.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
